// File: rtl/range_scan_pkg.sv
// Shared definitions for the range scan controller: FSM state encoding.
package range_scan_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StRun    = 2'd1;
  localparam state_t StFinish = 2'd2;

endpackage

// File: rtl/range_step_counter.sv
// Scan index register: loads a start value, steps by one and saturates at the end value.
module range_step_counter #(
  parameter int unsigned Bits = 8
) (
  input  logic            clk_i,
  input  logic            arst_ni,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [Bits-1:0] start_i,
  input  logic [Bits-1:0] end_i,
  output logic [Bits-1:0] idx_o,
  output logic            at_end_o
);

  logic [Bits-1:0] idx_q;

  assign idx_o    = idx_q;
  assign at_end_o = (idx_q == end_i);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      idx_q <= '0;
    end else if (load_i) begin
      idx_q <= start_i;
    end else if (en_i && !at_end_o) begin
      idx_q <= idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/range_scan_controller.sv
// Sweeps an index from start to end (inclusive) for a number of passes, with
// valid/ready flow control on the index stream and a synchronous abort.
module range_scan_controller
  import range_scan_pkg::*;
#(
  parameter int unsigned Bits     = 8,
  parameter int unsigned PassBits = 4
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [Bits-1:0]     cmd_start_i,
  input  logic [Bits-1:0]     cmd_end_i,
  input  logic [PassBits-1:0] cmd_passes_i,
  input  logic                abort_i,
  output logic                idx_valid_o,
  input  logic                idx_ready_i,
  output logic [Bits-1:0]     idx_o,
  output logic                idx_last_o,
  output logic                done_o,
  output logic                err_o
);

  state_t              state_q, state_d;
  logic [Bits-1:0]     start_q, end_q;
  logic [PassBits-1:0] passes_q, passes_d;
  logic                err_q, err_d;
  logic                init_q;
  logic                latch;
  logic                ctr_load, ctr_en, at_end;
  logic [Bits-1:0]     ctr_start;
  logic                final_pass, handshake;

  // Ready is withheld until the first edge after reset release.
  assign cmd_ready_o = init_q && (state_q == StIdle);
  assign idx_valid_o = (state_q == StRun);
  assign done_o      = (state_q == StFinish);
  assign err_o       = err_q;
  assign final_pass  = (passes_q <= PassBits'(1));
  assign handshake   = idx_valid_o && idx_ready_i;
  assign idx_last_o  = idx_valid_o && final_pass && at_end;

  // On accept the counter loads straight from the command so idx is valid next cycle.
  assign ctr_start = (state_q == StIdle) ? cmd_start_i : start_q;

  range_step_counter #(
    .Bits (Bits)
  ) u_counter (
    .clk_i    (clk_i),
    .arst_ni  (arst_ni),
    .load_i   (ctr_load),
    .en_i     (ctr_en),
    .start_i  (ctr_start),
    .end_i    (end_q),
    .idx_o    (idx_o),
    .at_end_o (at_end)
  );

  always_comb begin
    state_d  = state_q;
    passes_d = passes_q;
    err_d    = 1'b0;
    latch    = 1'b0;
    ctr_load = 1'b0;
    ctr_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_o) begin
          if (cmd_end_i < cmd_start_i) begin
            err_d = 1'b1;
          end else begin
            state_d  = StRun;
            latch    = 1'b1;
            ctr_load = 1'b1;
            passes_d = (cmd_passes_i == '0) ? PassBits'(1) : cmd_passes_i;
          end
        end
      end
      StRun: begin
        // Abort wins over a same-cycle handshake.
        if (abort_i) begin
          state_d = StFinish;
        end else if (handshake) begin
          if (!at_end) begin
            ctr_en = 1'b1;
          end else if (!final_pass) begin
            passes_d = passes_q - 1'b1;
            ctr_load = 1'b1;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= StIdle;
      start_q  <= '0;
      end_q    <= '0;
      passes_q <= '0;
      err_q    <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      passes_q <= passes_d;
      err_q    <= err_d;
      init_q   <= 1'b1;
      if (latch) begin
        start_q <= cmd_start_i;
        end_q   <= cmd_end_i;
      end
    end
  end

endmodule

// File: tb/tb_range_scan_controller.sv
// Self-checking bench for range_scan_controller: vector table plus corner-case sequences.
module tb_range_scan_controller;

  localparam int unsigned Bits     = 8;
  localparam int unsigned PassBits = 4;

  logic                clk_i = 1'b0;
  logic                arst_ni = 1'b0;
  logic                cmd_valid_i = 1'b0;
  logic                cmd_ready_o;
  logic [Bits-1:0]     cmd_start_i = '0;
  logic [Bits-1:0]     cmd_end_i = '0;
  logic [PassBits-1:0] cmd_passes_i = '0;
  logic                abort_i = 1'b0;
  logic                idx_valid_o;
  logic                idx_ready_i = 1'b0;
  logic [Bits-1:0]     idx_o;
  logic                idx_last_o;
  logic                done_o;
  logic                err_o;

  range_scan_controller #(
    .Bits     (Bits),
    .PassBits (PassBits)
  ) dut (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_start_i  (cmd_start_i),
    .cmd_end_i    (cmd_end_i),
    .cmd_passes_i (cmd_passes_i),
    .abort_i      (abort_i),
    .idx_valid_o  (idx_valid_o),
    .idx_ready_i  (idx_ready_i),
    .idx_o        (idx_o),
    .idx_last_o   (idx_last_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [Bits-1:0] idx;
    logic            last;
  } exp_t;

  exp_t sb_q[$];

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating
  typedef struct {
    int start;
    int stop;
    int passes;
    int mode;
    int abort_val;
    int exp_err;
    int exp_count;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_expected(input int s, input int e, input int p);
    int   n;
    exp_t t;
    n = (p == 0) ? 1 : p;
    for (int k = 0; k < n; k++) begin
      for (int v = s; v <= e; v++) begin
        t.idx  = Bits'(v);
        t.last = (k == n - 1) && (v == e);
        sb_q.push_back(t);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_idx"}, idx_o, 0);
    check({tag, "_idx_valid"}, idx_valid_o, 0);
    check({tag, "_idx_last"}, idx_last_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_cmd_ready"}, cmd_ready_o, 0);
  endtask

  task automatic run_cmd(input vec_t v);
    int cyc;
    int got;
    bit hs;
    cyc = 0;
    got = 0;
    while (!cmd_ready_o && cyc < 20) begin
      tick();
      cyc++;
    end
    check("cmd_ready_before_accept", cmd_ready_o, 1);
    cmd_valid_i  = 1'b1;
    cmd_start_i  = Bits'(v.start);
    cmd_end_i    = Bits'(v.stop);
    cmd_passes_i = PassBits'(v.passes);
    tick();
    cmd_valid_i = 1'b0;
    if (v.exp_err != 0) begin
      check("err_pulse", err_o, 1);
      check("err_no_valid", idx_valid_o, 0);
      check("err_ready_kept", cmd_ready_o, 1);
      tick();
      check("err_one_cycle", err_o, 0);
      check("err_no_valid2", idx_valid_o, 0);
      check("err_no_done", done_o, 0);
      return;
    end
    push_expected(v.start, v.stop, v.passes);
    check("idx_valid_latency", idx_valid_o, 1);
    check("err_quiet", err_o, 0);
    cyc = 0;
    while (idx_valid_o && cyc < 400) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", idx_valid_o, 0);
        break;
      end
      check("idx", idx_o, sb_q[0].idx);
      check("idx_last", idx_last_o, sb_q[0].last);
      check("run_cmd_ready", cmd_ready_o, 0);
      check("run_done", done_o, 0);
      idx_ready_i = (v.mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (v.abort_val >= 0 && int'(idx_o) == v.abort_val) abort_i = 1'b1;
      hs = idx_ready_i && !abort_i;
      tick();
      abort_i     = 1'b0;
      idx_ready_i = 1'b0;
      if (hs) begin
        void'(sb_q.pop_front());
        got++;
      end
      cyc++;
    end
    check("run_timeout", idx_valid_o, 0);
    check("done_pulse", done_o, 1);
    check("done_ready_low", cmd_ready_o, 0);
    check("idx_count", got, v.exp_count);
    if (v.abort_val >= 0) begin
      check("abort_not_consumed", (sb_q.size() > 0) ? int'(sb_q[0].idx) : -1, v.abort_val);
      sb_q.delete();
    end else begin
      check("sb_empty", sb_q.size(), 0);
    end
    tick();
    check("done_one_cycle", done_o, 0);
    check("ready_after_done", cmd_ready_o, 1);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    vecs.push_back('{start: 3,   stop: 6,   passes: 1, mode: 0, abort_val: -1, exp_err: 0, exp_count: 4});
    vecs.push_back('{start: 0,   stop: 1,   passes: 3, mode: 0, abort_val: -1, exp_err: 0, exp_count: 6});
    vecs.push_back('{start: 2,   stop: 4,   passes: 1, mode: 1, abort_val: -1, exp_err: 0, exp_count: 3});
    vecs.push_back('{start: 9,   stop: 5,   passes: 1, mode: 0, abort_val: -1, exp_err: 1, exp_count: 0});
    vecs.push_back('{start: 7,   stop: 7,   passes: 2, mode: 0, abort_val: -1, exp_err: 0, exp_count: 2});
    vecs.push_back('{start: 0,   stop: 0,   passes: 0, mode: 0, abort_val: -1, exp_err: 0, exp_count: 1});
    vecs.push_back('{start: 250, stop: 255, passes: 1, mode: 1, abort_val: -1, exp_err: 0, exp_count: 6});
    vecs.push_back('{start: 255, stop: 255, passes: 2, mode: 1, abort_val: -1, exp_err: 0, exp_count: 2});
    vecs.push_back('{start: 3,   stop: 10,  passes: 1, mode: 0, abort_val: 5,  exp_err: 0, exp_count: 2});
    vecs.push_back('{start: 1,   stop: 2,   passes: 2, mode: 0, abort_val: -1, exp_err: 0, exp_count: 4});

    // Power-on reset
    #2;
    check_all_zero("por");
    tick();
    arst_ni = 1'b1;
    #1;
    check("ready_before_first_edge", cmd_ready_o, 0);
    tick();
    check("ready_after_first_edge", cmd_ready_o, 1);
    check("idle_no_valid", idx_valid_o, 0);

    for (int i = 0; i < vecs.size(); i++) run_cmd(vecs[i]);

    // Abort while idle is ignored
    abort_i = 1'b1;
    tick();
    tick();
    check("idle_abort_ready", cmd_ready_o, 1);
    check("idle_abort_done", done_o, 0);
    abort_i = 1'b0;

    // Reset in the middle of a sweep
    cmd_valid_i  = 1'b1;
    cmd_start_i  = 8'd0;
    cmd_end_i    = 8'd20;
    cmd_passes_i = 4'd1;
    tick();
    cmd_valid_i = 1'b0;
    idx_ready_i = 1'b1;
    tick();
    tick();
    check("pre_reset_running", idx_valid_o, 1);
    idx_ready_i = 1'b0;
    arst_ni = 1'b0;
    #1;
    check_all_zero("rst_a");
    tick();
    check_all_zero("rst_b");
    tick();
    check_all_zero("rst_c");
    arst_ni = 1'b1;
    tick();
    check("rst_release_ready", cmd_ready_o, 1);
    check("rst_no_done", done_o, 0);
    check("rst_no_valid", idx_valid_o, 0);
    v = '{start: 4, stop: 6, passes: 1, mode: 0, abort_val: -1, exp_err: 0, exp_count: 3};
    run_cmd(v);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/range_scan_controller.md
RANGE_SCAN_CONTROLLER -- requirements
Module: range_scan_controller

Interface
REQ-001 Parameter Bits, default 8: width of every count/range field.
REQ-002 Parameter PassBits, default 4: width of the pass-count field.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk_i, input, 1: rising-edge clock for all state.
REQ-005 Port arst_ni, input, 1: asynchronous active-low reset.
REQ-006 Port cmd_valid_i, input, 1: command offered.
REQ-007 Port cmd_ready_o, output, 1: controller accepts a command.
REQ-008 Port cmd_start_i, input, Bits: first value of a sweep.
REQ-009 Port cmd_end_i, input, Bits: last value of a sweep, inclusive.
REQ-010 Port cmd_passes_i, input, PassBits: number of sweeps; 0 is treated as 1.
REQ-011 Port abort_i, input, 1: synchronous abort of the active command.
REQ-012 Port idx_valid_o, output, 1: idx_o holds a valid index.
REQ-013 Port idx_ready_i, input, 1: downstream consumes idx_o.
REQ-014 Port idx_o, output, Bits: current scan index.
REQ-015 Port idx_last_o, output, 1: idx_o equals cmd_end of the final pass.
REQ-016 Port done_o, output, 1: one-cycle pulse when a command completes or aborts.
REQ-017 Port err_o, output, 1: one-cycle pulse when a command is rejected.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and FINISH.
REQ-019 IDLE: cmd_ready_o=1 and idx_valid_o=0.
REQ-020 A command SHALL be accepted on a clock edge with cmd_valid_i=1 and cmd_ready_o=1, latching start, end and passes.
REQ-021 A command with cmd_end_i < cmd_start_i SHALL be rejected: err_o pulses the next cycle, and the FSM stays in IDLE.
REQ-022 Valid accept -> RUN; idx_o=start and idx_valid_o=1 on the cycle after acceptance (latency 1).
REQ-023 RUN: cmd_ready_o=0; idx_o and idx_valid_o SHALL hold while idx_valid_o=1 and idx_ready_i=0.
REQ-024 On handshake with idx_o<end: idx_o increments by 1 next cycle (Bits wide; no wrap, since end is at most all-ones).
REQ-025 On handshake with idx_o==end and passes remaining >1: decrement passes; idx_o reloads start next cycle.
REQ-026 On handshake with idx_o==end on the final pass: -> FINISH; idx_valid_o=0 next cycle.
REQ-027 start==end SHALL emit exactly one index per pass.
REQ-028 FINISH lasts one cycle, pulses done_o=1, then -> IDLE.
REQ-029 cmd_ready_o=0 in FINISH, so accept-to-accept spacing is at least N+2 cycles.
REQ-030 abort_i=1 in RUN SHALL take priority over a same-cycle handshake: -> FINISH, idx_valid_o=0 next cycle.
REQ-031 abort_i in IDLE or FINISH SHALL be ignored.
REQ-032 idx_last_o SHALL be combinational from state: RUN, final pass and idx_o==end.

Reset
REQ-033 While arst_ni=0: state=IDLE, idx_o=0, idx_valid_o=0, done_o=0, err_o=0, latched fields=0, cmd_ready_o=0.
REQ-034 On the first edge after deassertion, cmd_ready_o=1.
REQ-035 Reset mid-RUN SHALL discard the command, with no done_o pulse.

Structure
REQ-036 The state enum (IDLE/RUN/FINISH) SHALL live in the shared package range_scan_pkg.
REQ-037 The index register SHALL be a sub-module range_step_counter (load, enable, start/end, saturating at end); the FSM SHALL drive its load and enable.

Verification
REQ-038 start=3, end=6, passes=1, ready always 1 -> idx 3,4,5,6 on consecutive cycles; idx_last_o with 6; done_o one cycle later.
REQ-039 start=0, end=1, passes=3 -> sequence 0,1,0,1,0,1; idx_last_o only on the final 1.
REQ-040 start=2, end=4; idx_ready_i toggles 1,0,0,1,... -> idx_o holds during stalls; no index lost or duplicated.
REQ-041 start=9, end=5 -> err_o pulse; no idx_valid_o; cmd_ready_o stays 1.
REQ-042 abort_i asserted while idx_o=5 of 3..10 with ready=1 -> 5 not consumed; done_o next cycle; new command accepted afterwards.
REQ-043 arst_ni low for 2 cycles mid-RUN -> all outputs 0 during reset; no done_o; clean accept of a new command.
